// File: rtl/f_sequence_detector.sv
// rtl/f_sequence_detector.sv - overlapping bit-pattern detector on qualified F samples with saturating counters
// Optional idle timeout enabled by defining DETECT_TIMEOUT_EN.
module f_sequence_detector #(
  parameter int                 PAT_LEN        = 4,
  parameter logic [PAT_LEN-1:0] PATTERN        = 4'b1011,
  parameter int                 CNT_W          = 8,
  parameter int                 TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             f_in,
  input  logic             f_valid,
  input  logic             clear,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] ones_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [1:0]       state,
  output logic             halted,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FILL = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam int                 FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(PAT_LEN);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] window_q, window_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic [CNT_W-1:0]   ones_count_q, ones_count_d;
  logic [CNT_W-1:0]   sample_count_q, sample_count_d;
  logic               match_q, match_d;
  logic               accept;

`ifdef DETECT_TIMEOUT_EN
  localparam int             IDLE_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign accept = f_valid && (state_q != HALT);

  always_comb begin
    state_d        = state_q;
    window_d       = window_q;
    fill_d         = fill_q;
    match_count_d  = match_count_q;
    ones_count_d   = ones_count_q;
    sample_count_d = sample_count_q;
    match_d        = 1'b0;
`ifdef DETECT_TIMEOUT_EN
    idle_d         = idle_q;
    timeout_d      = 1'b0;
`endif
    if (clear) begin
      state_d        = IDLE;
      window_d       = '0;
      fill_d         = '0;
      match_count_d  = '0;
      ones_count_d   = '0;
      sample_count_d = '0;
`ifdef DETECT_TIMEOUT_EN
      idle_d         = '0;
`endif
    end else if (accept) begin
      window_d       = {window_q[PAT_LEN-2:0], f_in};
      fill_d         = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
      sample_count_d = sat_inc(sample_count_q);
      if (f_in) ones_count_d = sat_inc(ones_count_q);
      // The match test looks at the post-shift window so the completing bit counts.
      if ((fill_d == FILL_FULL) && (window_d == PATTERN)) begin
        match_d       = 1'b1;
        match_count_d = sat_inc(match_count_q);
      end
      if (match_count_d == CNT_MAX) state_d = HALT;
      else if (fill_d == FILL_FULL) state_d = RUN;
      else                          state_d = FILL;
`ifdef DETECT_TIMEOUT_EN
      idle_d = '0;
`endif
    end
`ifdef DETECT_TIMEOUT_EN
    else if ((state_q == FILL) || (state_q == RUN)) begin
      if (idle_q == IDLE_LAST) begin
        // Counters survive a timeout; only the partial pattern is discarded.
        state_d   = IDLE;
        window_d  = '0;
        fill_d    = '0;
        idle_d    = '0;
        timeout_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      window_q       <= '0;
      fill_q         <= '0;
      match_count_q  <= '0;
      ones_count_q   <= '0;
      sample_count_q <= '0;
      match_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      window_q       <= window_d;
      fill_q         <= fill_d;
      match_count_q  <= match_count_d;
      ones_count_q   <= ones_count_d;
      sample_count_q <= sample_count_d;
      match_q        <= match_d;
    end
  end

`ifdef DETECT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign match        = match_q;
  assign match_count  = match_count_q;
  assign ones_count   = ones_count_q;
  assign sample_count = sample_count_q;
  assign state        = state_q;
  assign halted       = (state_q == HALT);

endmodule

// File: tb/tb_f_sequence_detector.sv
// tb/tb_f_sequence_detector.sv - randomized self-checking bench for f_sequence_detector
// Two instances (CNT_W=8 and CNT_W=2) share stimulus; timeout checks follow DETECT_TIMEOUT_EN.
module tb_f_sequence_detector;
  localparam int PAT_LEN = 4;
  localparam int PATTERN = 'b1011;
  localparam int TO_CYC  = 16;

  logic clk = 1'b0, rst_n = 1'b0, f_in = 1'b0, f_valid = 1'b0, clear = 1'b0;
  logic       match_a, halted_a, timeout_a;
  logic [7:0] mc_a, oc_a, sc_a;
  logic [1:0] st_a;
  logic       match_b, halted_b, timeout_b;
  logic [1:0] mc_b, oc_b, sc_b;
  logic [1:0] st_b;

  int checks = 0, failures = 0;

  f_sequence_detector u_dut (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .f_valid(f_valid), .clear(clear),
    .match(match_a), .match_count(mc_a), .ones_count(oc_a), .sample_count(sc_a),
    .state(st_a), .halted(halted_a), .timeout(timeout_a)
  );

  f_sequence_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .f_in(f_in), .f_valid(f_valid), .clear(clear),
    .match(match_b), .match_count(mc_b), .ones_count(oc_b), .sample_count(sc_b),
    .state(st_b), .halted(halted_b), .timeout(timeout_b)
  );

  always #5 clk = ~clk;

  // Reference model: history of accepted bits plus capped integer counters.
  int m_hist[2], m_len[2], m_samp[2], m_ones[2], m_mcnt[2], m_idle[2], m_max[2];
  bit m_halt[2], m_match[2], m_to[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mreset(input int k);
    m_hist[k] = 0; m_len[k] = 0; m_samp[k] = 0; m_ones[k] = 0; m_mcnt[k] = 0;
    m_idle[k] = 0; m_halt[k] = 0; m_match[k] = 0; m_to[k] = 0;
  endtask

  function automatic int cap_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_step(input int k);
    m_match[k] = 0;
    m_to[k]    = 0;
    if (clear) begin
      mreset(k);
    end else if (!m_halt[k]) begin
      if (f_valid) begin
        m_hist[k] = ((m_hist[k] * 2) + int'(f_in)) % (1 << PAT_LEN);
        if (m_len[k] < PAT_LEN) m_len[k]++;
        m_samp[k] = cap_inc(m_samp[k], m_max[k]);
        if (f_in) m_ones[k] = cap_inc(m_ones[k], m_max[k]);
        if (m_len[k] == PAT_LEN && m_hist[k] == PATTERN) begin
          m_match[k] = 1;
          m_mcnt[k]  = cap_inc(m_mcnt[k], m_max[k]);
          if (m_mcnt[k] == m_max[k]) m_halt[k] = 1;
        end
        m_idle[k] = 0;
      end else begin
`ifdef DETECT_TIMEOUT_EN
        if (m_len[k] > 0) begin
          m_idle[k]++;
          if (m_idle[k] == TO_CYC) begin
            m_hist[k] = 0; m_len[k] = 0; m_idle[k] = 0; m_to[k] = 1;
          end
        end
`endif
      end
    end
  endtask

  function automatic int exp_state(input int k);
    if (m_halt[k]) return 3;
    if (m_len[k] == 0) return 0;
    if (m_len[k] < PAT_LEN) return 1;
    return 2;
  endfunction

  always @(negedge rst_n) begin
    mreset(0);
    mreset(1);
  end

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge clk) begin
    check("match[0]",   int'(match_a),   int'(m_match[0]));
    check("mcount[0]",  int'(mc_a),      m_mcnt[0]);
    check("ones[0]",    int'(oc_a),      m_ones[0]);
    check("samples[0]", int'(sc_a),      m_samp[0]);
    check("state[0]",   int'(st_a),      exp_state(0));
    check("halted[0]",  int'(halted_a),  int'(m_halt[0]));
    check("timeout[0]", int'(timeout_a), int'(m_to[0]));
    check("match[1]",   int'(match_b),   int'(m_match[1]));
    check("mcount[1]",  int'(mc_b),      m_mcnt[1]);
    check("ones[1]",    int'(oc_b),      m_ones[1]);
    check("samples[1]", int'(sc_b),      m_samp[1]);
    check("state[1]",   int'(st_b),      exp_state(1));
    check("halted[1]",  int'(halted_b),  int'(m_halt[1]));
    check("timeout[1]", int'(timeout_b), int'(m_to[1]));
  end

  task automatic step(input bit v, input bit b, input bit c);
    @(negedge clk);
    f_valid = v; f_in = b; clear = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit seq[10];
    int pulses, gap_pulses, gap_left;
    m_max[0] = 255;
    m_max[1] = 3;
    mreset(0);
    mreset(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Mid-cycle asynchronous reset
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    check("pre_reset_state", int'(st_a), 1);
    @(negedge clk);
    f_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(st_a), 0);
    check("async_rst_samples", int'(sc_a), 0);
    check("async_rst_ones", int'(oc_a), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic match with state sequence
    step(1, 1, 0); check("basic_st1", int'(st_a), 1);
    step(1, 0, 0); check("basic_st2", int'(st_a), 1);
    step(1, 1, 0); check("basic_st3", int'(st_a), 1);
    check("basic_nomatch3", int'(match_a), 0);
    step(1, 1, 0); check("basic_st4", int'(st_a), 2);
    check("basic_match", int'(match_a), 1);
    check("basic_mcount", int'(mc_a), 1);
    check("basic_ones", int'(oc_a), 3);
    check("basic_samples", int'(sc_a), 4);
    step(0, 0, 0); check("basic_match_drop", int'(match_a), 0);

    // Overlap with two-cycle gaps between bits
    step(0, 0, 1);
    seq = '{1, 0, 1, 1, 0, 1, 1, 0, 0, 0};
    pulses = 0; gap_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step(1, seq[i], 0);
      pulses += int'(match_a);
      repeat (2) begin
        step(0, 0, 0);
        gap_pulses += int'(match_a);
      end
    end
    check("overlap_pulses", pulses, 2);
    check("overlap_gap_pulses", gap_pulses, 0);
    check("overlap_mcount", int'(mc_a), 2);
    check("overlap_samples", int'(sc_a), 7);

    // Saturation of the narrow instance
    step(0, 0, 1);
    seq = '{1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
    for (int i = 0; i < 10; i++) step(1, seq[i], 0);
    check("sat_match_pulse", int'(match_b), 1);
    check("sat_mcount", int'(mc_b), 3);
    check("sat_state", int'(st_b), 3);
    check("sat_halted", int'(halted_b), 1);
    check("sat_samples", int'(sc_b), 3);
    check("wide_mcount", int'(mc_a), 3);
    check("wide_samples", int'(sc_a), 10);
    repeat (4) step(1, 1, 0);
    check("halt_mcount", int'(mc_b), 3);
    check("halt_samples", int'(sc_b), 3);
    check("halt_ones", int'(oc_b), 3);
    check("halt_match", int'(match_b), 0);
    step(0, 0, 1);
    check("halt_clear_mcount", int'(mc_b), 0);
    check("halt_clear_samples", int'(sc_b), 0);
    check("halt_clear_state", int'(st_b), 0);

    // clear beats a simultaneous sample
    step(1, 1, 0);
    step(1, 1, 1);
    check("collide_samples", int'(sc_a), 0);
    check("collide_ones", int'(oc_a), 0);
    check("collide_state", int'(st_a), 0);

`ifdef DETECT_TIMEOUT_EN
    step(0, 0, 1);
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
    repeat (15) step(0, 0, 0);
    check("to_early", int'(timeout_a), 0);
    step(0, 0, 0);
    check("to_pulse", int'(timeout_a), 1);
    check("to_state", int'(st_a), 0);
    check("to_samples", int'(sc_a), 3);
    step(0, 0, 0);
    check("to_pulse_drop", int'(timeout_a), 0);
    step(1, 1, 0);
    check("to_after_match", int'(match_a), 0);
    check("to_after_state", int'(st_a), 1);
    check("to_after_samples", int'(sc_a), 4);
`endif

    // Randomized traffic with occasional long gaps, clears and async resets
    gap_left = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      clear = ($urandom_range(0, 149) == 0);
      if (gap_left > 0) begin
        gap_left--;
        f_valid = 1'b0;
      end else begin
        if ($urandom_range(0, 199) == 0) gap_left = $urandom_range(10, 24);
        f_valid = ($urandom_range(0, 9) < 6);
      end
      f_in = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/f_sequence_detector.md
Name: f_sequence_detector

Overview:
- Downstream consumer of the combinational logic stage's F output. Samples F on qualified cycles and detects a parameterised bit pattern, with overlapping matches allowed.
- Keeps saturating sample, ones and match counters for lab-board display and self-checking benches.
- Sits between Combinational_Logic (F) and the display/LED stage.

Parameters:
- PAT_LEN, 4, pattern length in bits; legal range 2..8.
- PATTERN, 4'b1011, target sequence; MSB is the oldest bit, LSB the newest.
- CNT_W, 8, width of each counter.
- TIMEOUT_CYCLES, 16, idle-cycle limit; used only with DETECT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- f_in  in  1  F from the combinational stage.
- f_valid  in  1  sample qualifier; f_in is accepted on a rising edge when high.
- clear  in  1  synchronous clear of window, state and counters.
- match  out  1  one-cycle pulse on pattern completion.
- match_count  out  CNT_W  matches seen, saturating.
- ones_count  out  CNT_W  accepted samples equal to 1, saturating.
- sample_count  out  CNT_W  accepted samples, saturating.
- state  out  2  IDLE=00, FILL=01, RUN=10, HALT=11.
- halted  out  1  high while in HALT.
- timeout  out  1  one-cycle pulse on idle timeout; tied 0 when the feature is disabled.

Behaviour:
- Async reset (rst_n=0): all outputs 0, window 0, fill counter 0, state IDLE. Takes effect immediately, mid-stream included.
- Accept condition: f_valid=1, clear=0, state!=HALT. On accept, window <= {window[PAT_LEN-2:0], f_in}, sample_count+1, and ones_count+1 when f_in=1.
- Cycles with f_valid=0 hold all state. A gap does not break a partial match.
- IDLE -> FILL on the first accepted sample.
- FILL -> RUN on the PAT_LEN-th accepted sample. That sample may itself complete a match.
- RUN stays in RUN until HALT, clear or timeout.
- Match test uses the next window value (window after the shift) with fill reached; compare it to PATTERN.
- match is registered: high for exactly one cycle, following the edge that accepted the completing bit. Latency is 1 cycle.
- Overlap is allowed: 1011011 yields 2 matches.
- All counters saturate at 2^CNT_W-1 and never wrap.
- When match_count reaches all-ones, state goes to HALT and halted=1.
- In HALT, samples are ignored and counters are frozen. Only clear or rst_n exits HALT.
- clear=1: window, fill counter and all counters go to 0; state IDLE; match=0; timeout=0.
- clear has priority over a simultaneous f_valid; that sample is dropped.
- match and the HALT transition on the same edge: match still pulses and match_count shows the saturated value.

Optional Feature:
- Macro: DETECT_TIMEOUT_EN.
- When defined:
  - An idle counter counts consecutive cycles in FILL or RUN with f_valid=0. It resets on any accept, on clear, and on reset.
  - On reaching TIMEOUT_CYCLES, the window and fill counter are flushed, state returns to IDLE, and timeout pulses for 1 cycle.
  - Counters are retained through a timeout.
  - No timeout is raised in IDLE or HALT.
- When undefined: no idle counter is built and timeout is a constant 0.

Test Plan:
1. Reset: drive 1,0,1 with f_valid=1, then rst_n=0 mid-cycle -> all outputs 0 and state=00 before the next edge; after release, 1,0,1,1 still produces a match.
2. Basic match: 1,0,1,1 on consecutive cycles -> match high for exactly 1 cycle after the 4th edge; match_count=1, ones_count=3, sample_count=4; state sequence 00->01->01->01->10.
3. Overlap plus gaps: 1,0,1,1,0,1,1 with f_valid=0 for 2 cycles between every bit -> match_count=2, sample_count=7, no match pulse during gaps.
4. Saturation, CNT_W=2: 1,0,1,1,0,1,1,0,1,1 -> match_count=3, state=11, halted=1, sample_count=3 (saturated); 4 more samples leave all counters unchanged; then clear -> all counters 0, state=00.
5. clear collision: clear=1 with f_valid=1, f_in=1 in the same cycle -> sample_count=0, ones_count=0, state=00 next cycle.
6. DETECT_TIMEOUT_EN: 1,0,1, then 16 cycles with f_valid=0 -> timeout pulse 1 cycle, state=00, sample_count=3. A following single 1 gives no match, state=01, sample_count=4.
